// File: rtl/nano_pkg.sv
// Shared definitions for the nano_rv32i core: the canonical NOP, the default
// boot address and the fetch FSM state encoding.
package nano_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word-aligned request at a
// time over req/gnt/rvalid and presents the fetched word and its PC downstream.
module fetch_unit
  import nano_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         vld_q, vld_d;
  logic         discard_q, discard_d;
  logic         misalign_q, misalign_d;
  logic         started_q;
  logic         req_active;

  // The request is held off for the cycle right after reset release, so the
  // first request appears only after the first rising edge.
  assign req_active = (state_q == REQ) && started_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= RESET_PC;
      vld_q      <= 1'b0;
      discard_q  <= 1'b0;
      misalign_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      vld_q      <= vld_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
      started_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    vld_d      = vld_q;
    discard_d  = discard_q;
    misalign_d = 1'b0;

    if (redirect_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      vld_d      = 1'b0;
      instr_d    = NOP_INSTR;
      misalign_d = |redirect_pc_i[1:0];
      // A request already accepted by memory must have its response dropped.
      unique case (state_q)
        WAIT: begin
          if (imem_rvalid_i) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end
        end
        REQ: begin
          if (req_active && imem_gnt_i) begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end else begin
            discard_d = 1'b0;
            state_d   = REQ;
          end
        end
        default: begin
          discard_d = 1'b0;
          state_d   = REQ;
        end
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (req_active && imem_gnt_i) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = REQ;
            end else begin
              instr_d  = imem_rdata_i;
              pc_out_d = pc_q;
              vld_d    = 1'b1;
              pc_d     = pc_q + 32'd4;
              state_d  = OUT;
            end
          end
        end
        OUT: begin
          if (vld_q && ready_i) begin
            vld_d   = 1'b0;
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  assign imem_req_o  = req_active;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign valid_o     = vld_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-table bench for fetch_unit: each row gives the inputs driven in
// a cycle and the outputs expected during that same cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        ready;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (imem_gnt),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i (imem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_o      (instr),
    .pc_o         (pc),
    .valid_o      (valid),
    .ready_i      (ready),
    .misalign_o   (misalign)
  );

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

  function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic rd,
                              logic [31:0] rpc, logic rdy, logic e_req,
                              logic [31:0] e_addr, logic e_vld,
                              logic [31:0] e_instr, logic [31:0] e_pc,
                              logic e_mis);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, v.e_req});
    check({tag, ".addr"},  imem_addr,         v.e_addr);
    check({tag, ".valid"}, {31'd0, valid},    {31'd0, v.e_vld});
    check({tag, ".instr"}, instr,             v.e_instr);
    check({tag, ".pc"},    pc,                v.e_pc);
    check({tag, ".mis"},   {31'd0, misalign}, {31'd0, v.e_mis});
  endtask

  task automatic drive(input vec_t v);
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    redirect    = v.rd;
    redirect_pc = v.rpc;
    ready       = v.rdy;
  endtask

  task automatic run_table(input string tname, input vec_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      check_outputs($sformatf("%s[%0d]", tname, i), t[i]);
      drive(t[i]);
      @(negedge clk);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JNK = 32'hDEAD_BEEF;

  initial begin
    // gnt rv rdata rd rpc rdy | req addr vld instr pc mis
    tbl1.push_back(mk(0,0,0,0,0,1,  0,32'h0,        0,NOP,         32'h0,0)); // c0 reset release
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'h0,        0,NOP,         32'h0,0)); // c1 first request
    tbl1.push_back(mk(0,1,32'h93,0,0,1, 0,32'h0,    0,NOP,         32'h0,0)); // c2 wait
    tbl1.push_back(mk(0,0,0,0,0,1,  0,32'h4,        1,32'h93,      32'h0,0)); // c3 out
    tbl1.push_back(mk(0,0,0,0,0,1,  1,32'h4,        0,32'h93,      32'h0,0)); // c4 no gnt
    tbl1.push_back(mk(0,0,0,0,0,1,  1,32'h4,        0,32'h93,      32'h0,0));
    tbl1.push_back(mk(0,0,0,0,0,1,  1,32'h4,        0,32'h93,      32'h0,0));
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'h4,        0,32'h93,      32'h0,0)); // c7 grant
    tbl1.push_back(mk(0,1,32'h00100113,0,0,0, 0,32'h4, 0,32'h93,   32'h0,0));
    tbl1.push_back(mk(0,0,0,0,0,0,  0,32'h8,        1,32'h00100113,32'h4,0)); // c9 stall x5
    tbl1.push_back(mk(0,0,0,0,0,0,  0,32'h8,        1,32'h00100113,32'h4,0));
    tbl1.push_back(mk(1,1,JNK,0,0,0,0,32'h8,        1,32'h00100113,32'h4,0)); // stray rvalid
    tbl1.push_back(mk(0,0,0,0,0,0,  0,32'h8,        1,32'h00100113,32'h4,0));
    tbl1.push_back(mk(0,0,0,0,0,0,  0,32'h8,        1,32'h00100113,32'h4,0));
    tbl1.push_back(mk(0,0,0,0,0,1,  0,32'h8,        1,32'h00100113,32'h4,0)); // c14 accept
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'h8,        0,32'h00100113,32'h4,0)); // c15
    tbl1.push_back(mk(0,0,0,1,32'h100,1, 0,32'h8,   0,32'h00100113,32'h4,0)); // c16 redirect in WAIT
    tbl1.push_back(mk(0,1,JNK,0,0,1,0,32'h100,      0,NOP,         32'h4,0)); // c17 dropped
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'h100,      0,NOP,         32'h4,0)); // c18
    tbl1.push_back(mk(0,1,32'h00200113,0,0,1, 0,32'h100, 0,NOP,    32'h4,0));
    tbl1.push_back(mk(0,0,0,0,0,1,  0,32'h104,      1,32'h00200113,32'h100,0)); // c20
    tbl1.push_back(mk(0,0,0,1,32'h203,1, 1,32'h104, 0,32'h00200113,32'h100,0)); // c21 misaligned
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'h200,      0,NOP,         32'h100,1)); // c22 pulse
    tbl1.push_back(mk(0,1,32'h00300113,0,0,1, 0,32'h200, 0,NOP,    32'h100,0));
    tbl1.push_back(mk(0,0,0,1,32'hFFFF_FFFC,1, 0,32'h204, 1,32'h00300113,32'h200,0)); // c24 redirect+ready
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'hFFFF_FFFC,0,NOP,         32'h200,0)); // c25
    tbl1.push_back(mk(0,1,32'h00400113,0,0,1, 0,32'hFFFF_FFFC, 0,NOP, 32'h200,0));
    tbl1.push_back(mk(0,0,0,0,0,1,  0,32'h0,        1,32'h00400113,32'hFFFF_FFFC,0)); // c27 wrap
    tbl1.push_back(mk(1,0,0,1,32'h40,1, 1,32'h0,    0,32'h00400113,32'hFFFF_FFFC,0)); // c28 redirect+gnt
    tbl1.push_back(mk(0,1,JNK,0,0,1,0,32'h40,       0,NOP,         32'hFFFF_FFFC,0)); // c29 dropped
    tbl1.push_back(mk(1,0,0,0,0,1,  1,32'h40,       0,NOP,         32'hFFFF_FFFC,0)); // c30
    tbl1.push_back(mk(0,0,0,0,0,1,  0,32'h40,       0,NOP,         32'hFFFF_FFFC,0)); // c31 wait

    tbl2.push_back(mk(0,1,JNK,0,0,1,0,32'h0,        0,NOP,         32'h0,0)); // stale rvalid
    tbl2.push_back(mk(0,1,JNK,0,0,1,1,32'h0,        0,NOP,         32'h0,0)); // stale in REQ
    tbl2.push_back(mk(1,0,0,0,0,1,  1,32'h0,        0,NOP,         32'h0,0));
    tbl2.push_back(mk(0,1,32'h93,1,32'h80,1, 0,32'h0, 0,NOP,       32'h0,0)); // redirect+rvalid
    tbl2.push_back(mk(1,0,0,0,0,1,  1,32'h80,       0,NOP,         32'h0,0));
    tbl2.push_back(mk(0,1,32'h00500113,0,0,1, 0,32'h80, 0,NOP,     32'h0,0));
    tbl2.push_back(mk(0,0,0,0,0,1,  0,32'h84,       1,32'h00500113,32'h80,0));
    tbl2.push_back(mk(0,0,0,0,0,1,  1,32'h84,       0,32'h00500113,32'h80,0));

    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.req",   {31'd0, imem_req}, 32'd0);
    check("rst.addr",  imem_addr,         32'h0);
    check("rst.valid", {31'd0, valid},    32'd0);
    check("rst.instr", instr,             NOP);
    check("rst.pc",    pc,                32'h0);
    check("rst.mis",   {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;

    run_table("t1", tbl1);

    // Still in WAIT with address 0x40 outstanding; reset mid-cycle.
    check("prerst.addr", imem_addr, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.req",   {31'd0, imem_req}, 32'd0);
    check("midrst.valid", {31'd0, valid},    32'd0);
    check("midrst.addr",  imem_addr,         32'h0);
    check("midrst.instr", instr,             NOP);
    @(negedge clk);
    rst_n = 1'b1;

    run_table("t2", tbl2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
